// File: rtl/matrix_unloader_if.sv
// Handshake bundle between the result-side producer, the unloader and the output pins.
//
// Parameters:
//   DATA_W - width of the flat result matrix
//   OUT_W  - width of one output beat
//
// Signals:
//   res_mat, res_valid, res_ready  - capture side (matrix in, valid/ready)
//   dout, dout_valid, dout_ready   - narrow output stream (valid/ready)
//   dout_last                      - marks the final beat of a matrix
//   busy                           - a transfer is in progress
//
// Modports:
//   master - the unloader: drives res_ready and the output stream
//   slave  - the surrounding logic: drives the matrix and dout_ready
interface matrix_unloader_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned OUT_W  = 8
);

  logic [DATA_W-1:0] res_mat;
  logic              res_valid;
  logic              res_ready;
  logic [OUT_W-1:0]  dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              dout_last;
  logic              busy;

  modport master (
    input  res_mat,
    input  res_valid,
    output res_ready,
    output dout,
    output dout_valid,
    input  dout_ready,
    output dout_last,
    output busy
  );

  modport slave (
    output res_mat,
    output res_valid,
    input  res_ready,
    input  dout,
    input  dout_valid,
    output dout_ready,
    input  dout_last,
    input  busy
  );

endinterface

// File: rtl/matrix_unloader.sv
// Captures one flat result matrix and streams it out MSB-first, one OUT_W-bit beat per
// accepted valid/ready transfer.
//
// Optional feature macro: MATRIX_UNLOAD_CSUM_EN
//   When defined, a final extra beat carries the XOR of all data beats and dout_last moves
//   to that checksum beat.
//
// Parameters:
//   DATA_W - width of the flat result matrix (integer multiple of OUT_W)
//   OUT_W  - width of one output beat
//
// Ports:
//   CLK  - system clock, rising edge
//   RSTN - asynchronous active-low reset; aborts any transfer in flight
//   bus  - matrix_unloader_if.master: res_mat/res_valid/res_ready capture side,
//          dout/dout_valid/dout_ready/dout_last output stream, busy status
module matrix_unloader #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned OUT_W  = 8
) (
  input  logic               CLK,
  input  logic               RSTN,
  matrix_unloader_if.master  bus
);

  localparam int unsigned BEATS = DATA_W / OUT_W;
  localparam int unsigned CNT_W = $clog2(BEATS + 1);
`ifdef MATRIX_UNLOAD_CSUM_EN
  localparam int unsigned LAST_IDX = BEATS;
`else
  localparam int unsigned LAST_IDX = BEATS - 1;
`endif
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(LAST_IDX);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OUT_W-1:0]  top_beat;
  logic              is_last;

  assign top_beat = shift_q[DATA_W-1 -: OUT_W];
  assign is_last  = (cnt_q == LastCnt);

`ifdef MATRIX_UNLOAD_CSUM_EN
  localparam logic [CNT_W-1:0] CsumCnt = CNT_W'(BEATS);

  logic [OUT_W-1:0] csum_q, csum_d;
  logic             csum_beat;

  assign csum_beat = (cnt_q == CsumCnt);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  always_comb begin
    csum_d = csum_q;
    if (state_q == StIdle && bus.res_valid) begin
      csum_d = '0;
    end else if (state_q == StSend && bus.dout_ready && !csum_beat) begin
      // Accumulate only data beats as they actually transfer.
      csum_d = csum_q ^ top_beat;
    end
  end

  assign bus.dout = csum_beat ? csum_q : top_beat;
`else
  assign bus.dout = top_beat;
`endif

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        // res_ready is high throughout idle, so res_valid alone completes the handshake.
        if (bus.res_valid) begin
          state_d = StSend;
          shift_d = bus.res_mat;
          cnt_d   = '0;
        end
      end
      StSend: begin
        if (bus.dout_ready) begin
          shift_d = shift_q << OUT_W;
          if (is_last) begin
            state_d = StIdle;
          end else begin
            // Held on the final beat so the counter never needs to reach BEATS+1.
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.res_ready  = (state_q == StIdle);
  assign bus.dout_valid = (state_q == StSend);
  assign bus.busy       = (state_q == StSend);
  assign bus.dout_last  = (state_q == StSend) && is_last;

endmodule

// File: tb/tb_matrix_unloader.sv
// Directed bench for matrix_unloader: reset, basic stream, backpressure, ignored input while
// busy, back-to-back capture, reset mid-transfer, and the checksum beat when
// MATRIX_UNLOAD_CSUM_EN is defined.
module tb_matrix_unloader;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned OUT_W  = 8;
  localparam int unsigned BEATS  = 8;
`ifdef MATRIX_UNLOAD_CSUM_EN
  localparam int NB = BEATS + 1;
`else
  localparam int NB = BEATS;
`endif

  localparam logic [63:0] M1 = 64'h0102_0304_0506_0708;
  localparam logic [63:0] MF = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MA = 64'hA1A2_A3A4_A5A6_A7A8;
  localparam logic [63:0] M3 = 64'h1111_2222_3333_4444;

  logic CLK  = 1'b0;
  logic RSTN = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  matrix_unloader_if #(.DATA_W(DATA_W), .OUT_W(OUT_W)) u_if ();

  matrix_unloader #(.DATA_W(DATA_W), .OUT_W(OUT_W)) dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .bus  (u_if)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  // Expected beat i of a matrix: data bytes MSB-first, then the XOR of all data bytes.
  function automatic logic [7:0] exp_beat(input logic [63:0] mat, input int i);
    logic [7:0] x;
    if (i < int'(BEATS)) return mat[63 - 8*i -: 8];
    x = 8'h00;
    for (int k = 0; k < int'(BEATS); k++) x = x ^ mat[63 - 8*k -: 8];
    return x;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_valid"}, {63'd0, u_if.dout_valid}, 64'd0);
    chk({tag, "_busy"}, {63'd0, u_if.busy}, 64'd0);
    chk({tag, "_res_ready"}, {63'd0, u_if.res_ready}, 64'd1);
    chk({tag, "_last"}, {63'd0, u_if.dout_last}, 64'd0);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge where beat 0 is shown.
  task automatic capture(input logic [63:0] mat);
    u_if.res_mat   = mat;
    u_if.res_valid = 1'b1;
    @(negedge CLK);
    u_if.res_valid = 1'b0;
  endtask

  task automatic check_beat(input string tag, input logic [63:0] mat, input int i);
    chk($sformatf("%s_dout%0d", tag, i), {56'd0, u_if.dout}, {56'd0, exp_beat(mat, i)});
    chk($sformatf("%s_valid%0d", tag, i), {63'd0, u_if.dout_valid}, 64'd1);
    chk($sformatf("%s_last%0d", tag, i), {63'd0, u_if.dout_last}, {63'd0, i == NB - 1});
    chk($sformatf("%s_rdy%0d", tag, i), {63'd0, u_if.res_ready}, 64'd0);
    chk($sformatf("%s_busy%0d", tag, i), {63'd0, u_if.busy}, 64'd1);
  endtask

  // Walks the whole stream with dout_ready high, optionally stalling one beat and changing
  // the capture-side inputs at two chosen beats. Returns at the negedge after the last beat.
  task automatic stream(input string tag, input logic [63:0] mat,
                        input int stall_idx, input int stall_n,
                        input int c1_idx, input logic [63:0] c1_mat, input logic c1_v,
                        input int c2_idx, input logic [63:0] c2_mat, input logic c2_v);
    u_if.dout_ready = 1'b1;
    for (int i = 0; i < NB; i++) begin
      check_beat(tag, mat, i);
      if (i == c1_idx) begin
        u_if.res_mat   = c1_mat;
        u_if.res_valid = c1_v;
      end
      if (i == c2_idx) begin
        u_if.res_mat   = c2_mat;
        u_if.res_valid = c2_v;
      end
      if (i == stall_idx) begin
        u_if.dout_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          @(negedge CLK);
          check_beat({tag, "_hold"}, mat, i);
        end
        u_if.dout_ready = 1'b1;
      end
      @(negedge CLK);
    end
  endtask

  initial begin
    u_if.res_mat    = '0;
    u_if.res_valid  = 1'b0;
    u_if.dout_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge CLK);
    check_idle("reset");
    chk("reset_dout", {56'd0, u_if.dout}, 64'd0);
    RSTN = 1'b1;
    @(negedge CLK);
    check_idle("post_reset");

    // dout_ready has no effect while idle
    u_if.dout_ready = 1'b1;
    @(negedge CLK);
    check_idle("idle_ready_ignored");

    // Basic stream
    capture(M1);
    stream("basic", M1, -1, 0, -1, '0, 1'b0, -1, '0, 1'b0);
    check_idle("basic_done");

    // Backpressure on beat 03 for three cycles
    capture(M1);
    stream("bp", M1, 2, 3, -1, '0, 1'b0, -1, '0, 1'b0);
    check_idle("bp_done");

    // All-ones request ignored while busy, then the next matrix held valid for back-to-back
    capture(M1);
    stream("ign", M1, -1, 0, 1, MF, 1'b1, 5, MA, 1'b1);
    check_idle("b2b_bubble");
    @(negedge CLK);
    u_if.res_valid = 1'b0;
    u_if.res_mat   = '0;
    stream("b2b", MA, -1, 0, -1, '0, 1'b0, -1, '0, 1'b0);
    check_idle("b2b_done");

    // Reset asserted while beat 05 is presented
    capture(M1);
    for (int i = 0; i < 4; i++) begin
      check_beat("prerst", M1, i);
      @(negedge CLK);
    end
    check_beat("prerst", M1, 4);
    RSTN = 1'b0;
    #1;
    check_idle("mid_reset");
    chk("mid_reset_dout", {56'd0, u_if.dout}, 64'd0);
    @(negedge CLK);
    RSTN = 1'b1;
    @(negedge CLK);
    check_idle("after_reset");
    capture(M3);
    stream("post_rst", M3, -1, 0, -1, '0, 1'b0, -1, '0, 1'b0);
    check_idle("post_rst_done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
